sdm_dac_mod: RTL and testbench



---
 rtl/sdm_pkg.sv | 26 ++
 rtl/sdm_chan_core.sv | 85 ++++++++
 rtl/sdm_dac_mod.sv | 99 +++++++++
 tb/tb_sdm_dac_mod.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdm_pkg.sv
// Shared constants and helpers for the multi-channel delta-sigma DAC modulator.
package sdm_pkg;

   // Loop order encoding as seen on order_sel and in the registered order.
   localparam logic ORD_1 = 1'b0;
   localparam logic ORD_2 = 1'b1;

   // Second-order integrators carry this many guard bits above the sample width.
   localparam int INT_GUARD = 4;

   // Width of the signed second-order integrators for a given sample width.
   function automatic int int_w(input int data_w);
      return data_w + INT_GUARD;
   endfunction

   // Upper saturation limit of a signed integrator of width w (as a 64-bit value).
   function automatic longint sat_hi(input int w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction

   // Lower saturation limit of a signed integrator of width w (as a 64-bit value).
   function automatic longint sat_lo(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/sdm_chan_core.sv
// One modulator channel: first-order carry accumulator and second-order
// two-integrator loop, selected per tick by i_order. i_clr_state zeroes all
// loop state on the same tick, before that tick's update is applied.
module sdm_chan_core
   import sdm_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_tick,
   input  logic              i_clr_state,
   input  logic              i_order,
   input  logic [DATA_W-1:0] i_active,
   output logic              o_dout
);

   localparam int IW = int_w(DATA_W);
   // Extended width for the unsaturated sums so they can never wrap.
   localparam int EW = IW + 2;
   localparam logic signed [EW-1:0] SAT_HI = EW'(sat_hi(IW));
   localparam logic signed [EW-1:0] SAT_LO = EW'(sat_lo(IW));
   localparam logic signed [EW-1:0] HALF   = EW'(1) <<< (DATA_W - 1);

   // The accumulator's top bit (the carry) is only ever consumed as the output
   // bit, so only the low DATA_W bits are kept as state.
   logic [DATA_W-1:0]    r_acc;
   logic signed [IW-1:0] r_i1;
   logic signed [IW-1:0] r_i2;
   logic                 r_dout;

   logic [DATA_W-1:0]    w_acc_base;
   logic [DATA_W:0]      w_acc_sum;
   logic signed [EW-1:0] w_xs;
   logic signed [EW-1:0] w_y;
   logic signed [EW-1:0] w_i1_base;
   logic signed [EW-1:0] w_i2_base;
   logic signed [IW-1:0] w_i1_nxt;
   logic signed [IW-1:0] w_i2_nxt;

   function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
      logic signed [EW-1:0] c;
      if (v > SAT_HI)      c = SAT_HI;
      else if (v < SAT_LO) c = SAT_LO;
      else                 c = v;
      return c[IW-1:0];
   endfunction

   assign w_acc_base = i_clr_state ? '0 : r_acc;
   assign w_acc_sum  = {1'b0, w_acc_base} + {1'b0, i_active};

   assign w_xs      = signed'(EW'(i_active)) - HALF;
   assign w_y       = r_dout ? HALF : -HALF;
   assign w_i1_base = i_clr_state ? '0 : EW'(r_i1);
   assign w_i2_base = i_clr_state ? '0 : EW'(r_i2);
   assign w_i1_nxt  = sat(w_i1_base + w_xs - w_y);
   assign w_i2_nxt  = sat(w_i2_base + w_i1_base - w_y);

   // Loop state and output bit advance only on modulator ticks.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc  <= '0;
         r_i1   <= '0;
         r_i2   <= '0;
         r_dout <= 1'b0;
      end else if (i_tick) begin
         if (i_order == ORD_1) begin
            r_acc  <= w_acc_sum[DATA_W-1:0];
            r_dout <= w_acc_sum[DATA_W];
            if (i_clr_state) begin
               r_i1 <= '0;
               r_i2 <= '0;
            end
         end else begin
            r_i1   <= w_i1_nxt;
            r_i2   <= w_i2_nxt;
            r_dout <= ~w_i2_nxt[IW-1];
            if (i_clr_state) r_acc <= '0;
         end
      end
   end

   assign o_dout = r_dout;

endmodule

// File: rtl/sdm_dac_mod.sv
// Multi-channel delta-sigma DAC modulator top: tick divider, sample counter,
// double-buffered sample handshake, underrun flag and per-channel cores.
// Handshake: a sample set is accepted on any mod_clk edge where din_valid and
// din_ready are both high; din_ready is high exactly while the holding
// register is empty, and din_valid/mod_din need only be stable at that edge.
module sdm_dac_mod
   import sdm_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int CHANNELS = 2,
   parameter int CLK_DIV  = 1,
   parameter int OSR_LOG2 = 6
) (
   input  logic                         mod_clk,
   input  logic                         mod_rst,
   input  logic [CHANNELS*DATA_W-1:0]   mod_din,
   input  logic                         din_valid,
   output logic                         din_ready,
   input  logic                         order_sel,
   output logic                         underrun,
   input  logic                         underrun_clr,
   output logic                         sample_strobe,
   output logic [CHANNELS-1:0]          mod_dout
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0]           r_div;
   logic [OSR_LOG2-1:0]        r_tcnt;
   logic [CHANNELS*DATA_W-1:0] r_hold;
   logic [CHANNELS*DATA_W-1:0] r_active;
   logic                       r_full;
   logic                       r_underrun;
   logic                       r_order;

   logic                       w_tick;
   logic                       w_boundary;
   logic                       w_accept;
   logic                       w_clr;
   logic                       w_order;
   logic [CHANNELS-1:0]        w_dout;

   assign w_tick     = (r_div == DIV_LAST);
   assign w_boundary = w_tick && (r_tcnt == '1);
   assign w_accept   = din_valid && !r_full;
   // order_sel is only looked at on a boundary tick; a change there restarts the loops.
   assign w_order    = w_boundary ? order_sel : r_order;
   assign w_clr      = w_boundary && (order_sel != r_order);

   // Tick divider and ticks-per-sample counter.
   always_ff @(posedge mod_clk) begin
      if (mod_rst) begin
         r_div  <= '0;
         r_tcnt <= '0;
      end else begin
         r_div <= w_tick ? '0 : r_div + DIV_W'(1);
         if (w_tick) r_tcnt <= r_tcnt + OSR_LOG2'(1);
      end
   end

   // Holding/active double buffer, underrun flag and registered loop order.
   always_ff @(posedge mod_clk) begin
      if (mod_rst) begin
         r_hold     <= '0;
         r_active   <= '0;
         r_full     <= 1'b0;
         r_underrun <= 1'b0;
         r_order    <= ORD_1;
      end else begin
         if (w_accept) r_hold <= mod_din;
         if (w_boundary && r_full) r_active <= r_hold;
         if (w_accept)        r_full <= 1'b1;
         else if (w_boundary) r_full <= 1'b0;
         // A boundary on an empty holding register beats a concurrent clear.
         if (w_boundary && !r_full) r_underrun <= 1'b1;
         else if (underrun_clr)     r_underrun <= 1'b0;
         if (w_boundary) r_order <= order_sel;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      sdm_chan_core #(.DATA_W(DATA_W)) u_core (
         .i_clk       (mod_clk),
         .i_rst       (mod_rst),
         .i_tick      (w_tick),
         .i_clr_state (w_clr),
         .i_order     (w_order),
         .i_active    (r_active[c*DATA_W +: DATA_W]),
         .o_dout      (w_dout[c])
      );
   end

   assign din_ready     = ~r_full;
   assign underrun      = r_underrun;
   assign sample_strobe = w_boundary && !mod_rst;
   assign mod_dout      = w_dout;

endmodule

// File: tb/tb_sdm_dac_mod.sv
// Directed bench for sdm_dac_mod: instance a runs with CLK_DIV=1, instance b
// with CLK_DIV=3; both use 16-bit samples, 2 channels and 64 ticks per sample.
module tb_sdm_dac_mod;

  logic        clk = 1'b0;
  logic        rst, rst_b;
  logic [31:0] din, din_b;
  logic        din_valid, din_valid_b;
  logic        order_sel, order_sel_b;
  logic        underrun_clr, underrun_clr_b;
  logic        ready, ready_b;
  logic        underrun, underrun_b;
  logic        strobe, strobe_b;
  logic [1:0]  dout, dout_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdm_dac_mod #(.DATA_W(16), .CHANNELS(2), .CLK_DIV(1), .OSR_LOG2(6)) dut_a (
    .mod_clk(clk), .mod_rst(rst), .mod_din(din), .din_valid(din_valid),
    .din_ready(ready), .order_sel(order_sel), .underrun(underrun),
    .underrun_clr(underrun_clr), .sample_strobe(strobe), .mod_dout(dout)
  );

  sdm_dac_mod #(.DATA_W(16), .CHANNELS(2), .CLK_DIV(3), .OSR_LOG2(6)) dut_b (
    .mod_clk(clk), .mod_rst(rst_b), .mod_din(din_b), .din_valid(din_valid_b),
    .din_ready(ready_b), .order_sel(order_sel_b), .underrun(underrun_b),
    .underrun_clr(underrun_clr_b), .sample_strobe(strobe_b), .mod_dout(dout_b)
  );

  // One clock edge; outputs are then read 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; underrun_clr = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Advance until the selected instance shows sample_strobe, within a cycle budget.
  task automatic wait_strobe(input bit use_b, input int budget);
    int n;
    n = 0;
    while (!(use_b ? strobe_b : strobe) && n < budget) begin
      step();
      n++;
    end
    n_cmp++;
    if (!(use_b ? strobe_b : strobe)) begin
      n_err++;
      $display("FAIL wait_strobe: no strobe after %0d cycles, required within %0d", n, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; din_valid = 1'b1; din = 32'hFFFF_FFFF; order_sel = 1'b0; underrun_clr = 1'b0;
    step(); step();
    n_cmp++; if (dout !== 2'b00) begin n_err++; $display("FAIL reset_dout: got %b required 00", dout); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b required 1", ready); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b required 0", underrun); end
    n_cmp++; if (strobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %b required 0", strobe); end
    rst = 1'b0; din_valid = 1'b0;
  endtask

  task automatic test_order1_mid();
    logic [7:0] seq;
    int ones0, ones1;
    do_reset();
    order_sel = 1'b0;
    din = {16'h1234, 16'h8000}; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL o1_ready_after_accept: got %b required 0", ready); end
    wait_strobe(1'b0, 200);
    step();
    seq = '0; ones0 = 0; ones1 = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (k < 8) seq[k] = dout[0];
      ones0 += int'(dout[0]);
      ones1 += int'(dout[1]);
    end
    n_cmp++; if (seq !== 8'hAA) begin n_err++; $display("FAIL o1_mid_pattern: got %b required 10101010", seq); end
    n_cmp++; if (ones0 != 32) begin n_err++; $display("FAIL o1_mid_ones: got %0d required 32", ones0); end
    n_cmp++; if (ones1 != 4) begin n_err++; $display("FAIL o1_1234_ones: got %0d required 4", ones1); end
  endtask

  task automatic test_order1_extremes();
    int ones0, ones1;
    do_reset();
    order_sel = 1'b0;
    din = {16'hFFFF, 16'h0000}; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    wait_strobe(1'b0, 200);
    step();
    ones0 = 0; ones1 = 0;
    for (int k = 0; k < 65536; k++) begin
      step();
      ones0 += int'(dout[0]);
      ones1 += int'(dout[1]);
    end
    n_cmp++; if (ones0 != 0) begin n_err++; $display("FAIL o1_zero_ones: got %0d required 0", ones0); end
    n_cmp++; if (ones1 != 65535) begin n_err++; $display("FAIL o1_full_ones: got %0d required 65535", ones1); end
  endtask

  task automatic test_order2();
    logic [7:0] seq;
    int ones0, ones1;
    bit ur_seen;
    do_reset();
    order_sel = 1'b1;
    din = {16'hA000, 16'h8000}; din_valid = 1'b1;
    wait_strobe(1'b0, 200);
    step();
    seq = '0; ones0 = 0; ones1 = 0; ur_seen = 1'b0;
    for (int k = 0; k < 4096; k++) begin
      step();
      if (k < 8) seq[k] = dout[0];
      ones0 += int'(dout[0]);
      ones1 += int'(dout[1]);
      if (underrun) ur_seen = 1'b1;
    end
    din_valid = 1'b0; order_sel = 1'b0;
    n_cmp++; if (seq !== 8'hE1) begin n_err++; $display("FAIL o2_start_pattern: got %b required 11100001", seq); end
    n_cmp++; if (ones0 < 2046 || ones0 > 2050) begin n_err++; $display("FAIL o2_mid_ones: got %0d required 2048+-2", ones0); end
    n_cmp++; if (ones1 < 2558 || ones1 > 2562) begin n_err++; $display("FAIL o2_a000_ones: got %0d required 2560+-2", ones1); end
    n_cmp++; if (ur_seen) begin n_err++; $display("FAIL o2_underrun: got 1 required 0"); end
  endtask

  task automatic test_handshake();
    int accepts, ones;
    do_reset();
    order_sel = 1'b0;
    din = {16'h0000, 16'h8000}; din_valid = 1'b1;
    step();
    wait_strobe(1'b0, 200);
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL hs_ready_at_boundary: got %b required 0", ready); end
    step();
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL hs_ready_after_boundary: got %b required 1", ready); end
    accepts = 0;
    for (int k = 0; k < 192; k++) begin
      if (din_valid && ready) accepts++;
      step();
    end
    n_cmp++; if (accepts != 3) begin n_err++; $display("FAIL hs_accepts: got %0d required 3", accepts); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL hs_no_underrun: got %b required 0", underrun); end
    // Last sample, then the source goes quiet.
    din = {16'h0000, 16'h4000};
    step();
    din_valid = 1'b0;
    wait_strobe(1'b0, 200);
    step();
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL hs_last_transfer: got %b required 0", underrun); end
    ones = 0;
    for (int k = 0; k < 64; k++) begin step(); ones += int'(dout[0]); end
    n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL ur_set: got %b required 1", underrun); end
    n_cmp++; if (ones != 16) begin n_err++; $display("FAIL ur_ones_p1: got %0d required 16", ones); end
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    ones = int'(dout[0]);
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL ur_clear: got %b required 0", underrun); end
    for (int k = 0; k < 62; k++) begin step(); ones += int'(dout[0]); end
    n_cmp++; if (strobe !== 1'b1) begin n_err++; $display("FAIL ur_strobe_pos: got %b required 1", strobe); end
    underrun_clr = 1'b1;
    step();
    ones += int'(dout[0]);
    underrun_clr = 1'b0;
    n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL ur_set_wins: got %b required 1", underrun); end
    n_cmp++; if (ones != 16) begin n_err++; $display("FAIL ur_repeat_ones: got %0d required 16", ones); end
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    for (int k = 0; k < 62; k++) step();
    din = {16'h0000, 16'h8000}; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL ur_accept_at_boundary: got %b required 1", underrun); end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL ur_accept_loaded: got %b required 0", ready); end
    wait_strobe(1'b0, 200);
    step();
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL ur_accept_transfer: got %b required 1", ready); end
  endtask

  task automatic test_clkdiv3_order();
    int n, bad_edges, bad_vals;
    logic prev;
    logic [7:0] seq;
    rst_b = 1'b1; din_valid_b = 1'b0; underrun_clr_b = 1'b0; order_sel_b = 1'b0;
    step(); step();
    rst_b = 1'b0;
    din_b = {16'h0000, 16'h8000}; din_valid_b = 1'b1;
    step();
    din_valid_b = 1'b0;
    wait_strobe(1'b1, 800);
    n = 0; bad_edges = 0; bad_vals = 0; prev = dout_b[0];
    // Edge k=1 is the boundary tick; later ticks fall on edges 1+3j.
    while (n < 400) begin
      step();
      n++;
      if (n == 50) order_sel_b = 1'b1;
      if ((n - 1) % 3 != 0 && dout_b[0] !== prev) bad_edges++;
      if ((n - 1) % 3 == 0 && n > 1 && dout_b[0] !== (((n - 1) / 3) % 2 == 0 ? 1'b1 : 1'b0)) bad_vals++;
      prev = dout_b[0];
      if (strobe_b) break;
    end
    n_cmp++; if (n != 192) begin n_err++; $display("FAIL div3_strobe_period: got %0d required 192", n); end
    n_cmp++; if (bad_edges != 0) begin n_err++; $display("FAIL div3_hold_between_ticks: got %0d changes required 0", bad_edges); end
    n_cmp++; if (bad_vals != 0) begin n_err++; $display("FAIL div3_order1_until_strobe: got %0d wrong ticks required 0", bad_vals); end
    seq = '0;
    for (int m = 0; m < 8; m++) begin
      step();
      seq[m] = dout_b[0];
      step(); step();
    end
    n_cmp++; if (seq !== 8'h87) begin n_err++; $display("FAIL div3_order2_after_strobe: got %b required 10000111", seq); end
  endtask

  task automatic test_mid_reset();
    int n;
    do_reset();
    order_sel = 1'b0;
    din = {16'h1111, 16'h2222}; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    wait_strobe(1'b0, 200);
    step();
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int k = 0; k < 20; k++) step();
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL mr_holding_full: got %b required 0", ready); end
    rst = 1'b1; din_valid = 1'b1;
    step();
    rst = 1'b0; din_valid = 1'b0;
    n_cmp++; if (dout !== 2'b00) begin n_err++; $display("FAIL mr_dout: got %b required 00", dout); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL mr_ready: got %b required 1", ready); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL mr_underrun: got %b required 0", underrun); end
    n_cmp++; if (strobe !== 1'b0) begin n_err++; $display("FAIL mr_strobe: got %b required 0", strobe); end
    // Strobe shows after 63 edges; the boundary itself is the 64th tick.
    n = 0;
    while (!strobe && n < 200) begin step(); n++; end
    n_cmp++; if (n != 63) begin n_err++; $display("FAIL mr_first_strobe: got %0d required 63", n); end
  endtask

  initial begin
    rst_b = 1'b1; din_b = '0; din_valid_b = 1'b0; order_sel_b = 1'b0; underrun_clr_b = 1'b0;
    rst = 1'b1; din = '0; din_valid = 1'b0; order_sel = 1'b0; underrun_clr = 1'b0;
    test_reset();
    test_order1_mid();
    test_order1_extremes();
    test_order2();
    test_handshake();
    test_clkdiv3_order();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
